// File: rtl/stream_upsizer.sv
// ============================================================================
// Module   : stream_upsizer
// Brief    : Packs RATIO beats of DATA_SIZE bits into one word, lane 0 first.
//            Optional macro STREAM_UPSIZER_LAST_EN adds early close on
//            data_last_i with data_keep_o / data_last_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_upsizer #(
  parameter int DATA_SIZE = 8,
  parameter int RATIO     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_clk_ni,
  input  logic [DATA_SIZE-1:0]         data_i,
  input  logic                         data_valid_i,
  output logic                         data_ready_o,
`ifdef STREAM_UPSIZER_LAST_EN
  input  logic                         data_last_i,
  output logic                         data_last_o,
  output logic [RATIO-1:0]             data_keep_o,
`endif
  output logic [DATA_SIZE*RATIO-1:0]   data_o,
  output logic                         data_valid_o,
  input  logic                         data_ready_i
);

  localparam int          c_CW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(RATIO - 1);

  logic [c_CW-1:0]            r_cnt;
  logic [DATA_SIZE*RATIO-1:0] r_acc;
  logic [DATA_SIZE*RATIO-1:0] r_data;
  logic                       r_valid;

  logic                       w_close;
  logic                       w_in_fire;
  logic                       w_out_fire;
  logic [DATA_SIZE*RATIO-1:0] w_word;

`ifdef STREAM_UPSIZER_LAST_EN
  logic                       r_last;
  logic [RATIO-1:0]           r_keep;
  logic [RATIO-1:0]           w_keep;

  assign w_close = (r_cnt == c_LAST) || data_last_i;

  always_comb begin
    w_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      w_keep[i] = (c_CW'(i) <= r_cnt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_clk_ni) begin
      r_last <= 1'b0;
      r_keep <= '0;
    end else if (w_in_fire && w_close) begin
      r_last <= data_last_i;
      r_keep <= w_keep;
    end
  end

  assign data_last_o = r_last;
  assign data_keep_o = r_keep;
`else
  assign w_close = (r_cnt == c_LAST);
`endif

  // Ready is forced high in reset; only a closing beat can be back-pressured.
  assign data_ready_o = !rst_clk_ni || !w_close || !r_valid || data_ready_i;
  assign w_in_fire    = data_valid_i && data_ready_o;
  assign w_out_fire   = r_valid && data_ready_i;

  always_comb begin
    w_word = r_acc;
    w_word[int'(r_cnt)*DATA_SIZE +: DATA_SIZE] = data_i;
  end

  // The accumulator is cleared on close so unused lanes of a short word are 0.
  always_ff @(posedge clk_i) begin
    if (!rst_clk_ni) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_in_fire && w_close) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else begin
      if (w_in_fire) begin
        r_cnt <= r_cnt + c_CW'(1);
        r_acc <= w_word;
      end
      if (w_out_fire) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_stream_upsizer.sv
// ============================================================================
// Module   : tb_stream_upsizer
// Brief    : Directed and scoreboard checks of stream_upsizer (8 bit x 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_upsizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        vin;
  logic        rdy_o;
  logic [31:0] dout;
  logic        vout;
  logic        rdy;
`ifdef STREAM_UPSIZER_LAST_EN
  logic        lst_i;
  logic        lst_o;
  logic [3:0]  keep_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_upsizer #(.DATA_SIZE(8), .RATIO(4)) dut (
    .clk_i        (clk),
    .rst_clk_ni   (rst_n),
    .data_i       (din),
    .data_valid_i (vin),
    .data_ready_o (rdy_o),
`ifdef STREAM_UPSIZER_LAST_EN
    .data_last_i  (lst_i),
    .data_last_o  (lst_o),
    .data_keep_o  (keep_o),
`endif
    .data_o       (dout),
    .data_valid_o (vout),
    .data_ready_i (rdy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one cycle, expecting it to be accepted.
  task automatic beat(input logic [7:0] d);
    din = d;
    vin = 1'b1;
    #1;
    check("beat_ready", rdy_o, 1'b1);
    tick;
    vin = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q[$];
    logic [31:0] exp_w;
    logic        acc;
    int          sent;
    int          words;
    int          cyc;

    rst_n = 1'b0;
    din   = 8'h5A;
    vin   = 1'b1;
    rdy   = 1'b1;
`ifdef STREAM_UPSIZER_LAST_EN
    lst_i = 1'b0;
`endif
    tick;
    tick;
    check("rst_ready", rdy_o, 1'b1);
    check("rst_valid", vout, 1'b0);
    check("rst_data", dout, 32'h0);
    vin   = 1'b0;
    rst_n = 1'b1;
    tick;

    // Basic word, one cycle latency, valid for one cycle
    beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
    check("basic_valid", vout, 1'b1);
    check("basic_data", dout, 32'h44332211);
    tick;
    check("basic_valid_drop", vout, 1'b0);

    // Back-to-back beats: ready never drops, words 4 cycles apart
    for (int k = 0; k < 8; k++) begin
      din = 8'(k + 1);
      vin = 1'b1;
      #1;
      check("b2b_ready", rdy_o, 1'b1);
      tick;
      check("b2b_valid", vout, (k % 4) == 3);
      if (k == 3) check("b2b_word0", dout, 32'h04030201);
      if (k == 7) check("b2b_word1", dout, 32'h08070605);
    end
    vin = 1'b0;
    tick;

    // Output stall: 3 beats accepted, 4th held off, data_o stable
    rdy = 1'b0;
    beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
    check("stall_valid", vout, 1'b1);
    check("stall_word0", dout, 32'h44332211);
    for (int k = 0; k < 4; k++) begin
      din = 8'h55 + 8'(k * 8'h11);
      vin = 1'b1;
      #1;
      check("stall_ready", rdy_o, k < 3);
      tick;
      check("stall_hold", dout, 32'h44332211);
    end
    #1;
    check("stall_ready_hold", rdy_o, 1'b0);
    tick;
    check("stall_hold2", dout, 32'h44332211);
    check("stall_valid2", vout, 1'b1);
    rdy = 1'b1;
    #1;
    check("stall_ready_release", rdy_o, 1'b1);
    tick;
    vin = 1'b0;
    check("stall_valid3", vout, 1'b1);
    check("stall_word1", dout, 32'h88776655);
    tick;
    check("stall_valid_drop", vout, 1'b0);

    // Reset mid-word discards partial beats
    beat(8'hAA); beat(8'hBB);
    rst_n = 1'b0;
    din   = 8'hCC;
    vin   = 1'b1;
    #1;
    check("midrst_ready", rdy_o, 1'b1);
    tick;
    vin   = 1'b0;
    rst_n = 1'b1;
    check("midrst_valid", vout, 1'b0);
    check("midrst_data", dout, 32'h0);
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    check("midrst_word_valid", vout, 1'b1);
    check("midrst_word", dout, 32'h04030201);
    tick;

`ifdef STREAM_UPSIZER_LAST_EN
    // Early close on last
    beat(8'h11);
    lst_i = 1'b1;
    beat(8'h22);
    lst_i = 1'b0;
    check("last_valid", vout, 1'b1);
    check("last_data", dout, 32'h00002211);
    check("last_keep", keep_o, 4'b0011);
    check("last_flag", lst_o, 1'b1);
    tick;
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    check("after_last_data", dout, 32'h04030201);
    check("after_last_keep", keep_o, 4'b1111);
    check("after_last_flag", lst_o, 1'b0);
    tick;
`endif

    // Random-stall soak against a beat queue scoreboard
    sent  = 0;
    words = 0;
    cyc   = 0;
    vin   = 1'b0;
    while ((sent < 1024 || words < 256) && cyc < 20000) begin
      if (!vin && sent < 1024 && $urandom_range(0, 3) != 0) begin
        vin = 1'b1;
        din = 8'($urandom);
      end
      rdy = ($urandom_range(0, 2) != 0);
      #1;
      if (vout && rdy) begin
        if (q.size() < 4) begin
          check("soak_underflow", 64'(q.size()), 64'd4);
        end else begin
          exp_w = {q[3], q[2], q[1], q[0]};
          repeat (4) void'(q.pop_front());
          check("soak_word", dout, exp_w);
        end
        words++;
      end
      acc = vin && rdy_o;
      if (acc) begin
        q.push_back(din);
        sent++;
      end
      tick;
      if (acc) vin = 1'b0;
      cyc++;
    end
    vin = 1'b0;
    check("soak_beats", 64'(sent), 64'd1024);
    check("soak_words", 64'(words), 64'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
